// File: rtl/imem_load_controller.sv
// Instruction-memory arbiter between the core's fetch path and a program-load stream.
// RUN passes fetches straight through. LOAD stalls the core and writes streamed words
// from address 0 upward. DONE is a single cycle that pulses done before the core resumes.
module imem_load_controller #(
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned CNT_W         = 6,
  parameter bit          LOAD_ON_RESET = 1'b0,
  parameter logic [31:0] NOP_WORD      = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [CNT_W-1:0] load_len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  input  logic [31:0]      cpu_A,
  output logic [31:0]      cpu_RD,
  output logic             cpu_stall,
  output logic             fetch_oob,
  output logic [31:0]      mem_A,
  output logic             mem_WE,
  output logic [31:0]      mem_WD,
  input  logic [31:0]      mem_RD,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [1:0] {StRun, StLoad, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] ptr_q;
  logic [CNT_W-1:0] words_q;
  logic             done_q;
  logic             err_q;

  logic len_ok;
  logic cpu_in_range;
  logic last_word;

  assign len_ok       = (load_len != '0) && (load_len <= CNT_W'(DEPTH));
  assign cpu_in_range = cpu_A < 32'(DEPTH);
  assign last_word    = (ptr_q == len_q - CNT_W'(1));

  // Control FSM: state, load length, write pointer and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_ON_RESET ? StLoad : StRun;
      len_q   <= LOAD_ON_RESET ? CNT_W'(DEPTH) : '0;
      ptr_q   <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (load_start) begin
            if (len_ok) begin
              len_q   <= load_len;
              ptr_q   <= '0;
              words_q <= '0;
              state_q <= StLoad;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (s_valid) begin
            words_q <= words_q + CNT_W'(1);
            if (last_word) begin
              // Pointer is left at len-1 so it never runs past the loaded region.
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + CNT_W'(1);
            end
          end
        end
        StDone: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  // Datapath steering for memory, core and loader, decoded from the current state.
  always_comb begin
    mem_A     = cpu_A;
    mem_WE    = 1'b0;
    mem_WD    = 32'h0;
    s_ready   = 1'b0;
    cpu_stall = 1'b0;
    busy      = 1'b0;
    cpu_RD    = NOP_WORD;
    fetch_oob = 1'b0;
    unique case (state_q)
      StRun: begin
        if (cpu_in_range) begin
          cpu_RD = mem_RD;
        end else begin
          fetch_oob = 1'b1;
        end
      end
      StLoad: begin
        mem_A     = {{(32-CNT_W){1'b0}}, ptr_q};
        mem_WE    = s_valid;
        mem_WD    = s_data;
        s_ready   = 1'b1;
        cpu_stall = 1'b1;
        busy      = 1'b1;
      end
      StDone: begin
        mem_A     = {{(32-CNT_W){1'b0}}, ptr_q};
        cpu_stall = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        cpu_stall = 1'b1;
      end
    endcase
  end

  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed bench for imem_load_controller; dut0 uses defaults, dut1 loads on reset.
module tb_imem_load_controller;

  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_start;
  logic [CNT_W-1:0] load_len;
  logic             s_valid;
  logic [31:0]      s_data;
  logic [31:0]      cpu_A;
  logic [31:0]      mem_RD;

  logic             s_ready, cpu_stall, fetch_oob, mem_WE, busy, done, err;
  logic [31:0]      cpu_RD, mem_A, mem_WD;
  logic [CNT_W-1:0] words_loaded;

  logic             s_ready1, cpu_stall1, fetch_oob1, mem_WE1, busy1, done1, err1;
  logic [31:0]      cpu_RD1, mem_A1, mem_WD1;
  logic [CNT_W-1:0] words_loaded1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  imem_load_controller dut0 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .cpu_A(cpu_A),
    .cpu_RD(cpu_RD), .cpu_stall(cpu_stall), .fetch_oob(fetch_oob), .mem_A(mem_A),
    .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD), .busy(busy), .done(done),
    .err(err), .words_loaded(words_loaded)
  );

  imem_load_controller #(.LOAD_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1), .cpu_A(cpu_A),
    .cpu_RD(cpu_RD1), .cpu_stall(cpu_stall1), .fetch_oob(fetch_oob1), .mem_A(mem_A1),
    .mem_WE(mem_WE1), .mem_WD(mem_WD1), .mem_RD(mem_RD), .busy(busy1), .done(done1),
    .err(err1), .words_loaded(words_loaded1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic pat [6];
    int   nw;

    reset = 1'b1; load_start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
    cpu_A = 32'd3; mem_RD = 32'd4000;
    tick();
    tick();
    reset = 1'b0;
    #1;
    // Reset state and pass-through fetch.
    chk("rst_cpu_RD", cpu_RD, 32'd4000);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_oob", fetch_oob, 0);
    chk("rst_we", mem_WE, 0);
    chk("rst_mem_A", mem_A, 32'd3);
    chk("rst_busy", busy, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_wl", words_loaded, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Four-word back-to-back load.
    load_start = 1'b1; load_len = 6'd4;
    tick();
    load_start = 1'b0;
    chk("l4_err", err, 0);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'hA0 + i;
      #1;
      chk("l4_we", mem_WE, 1);
      chk("l4_addr", mem_A, i);
      chk("l4_wd", mem_WD, 32'hA0 + i);
      chk("l4_stall", cpu_stall, 1);
      chk("l4_cpu_RD", cpu_RD, 32'h0);
      chk("l4_done_early", done, 0);
      tick();
    end
    s_valid = 1'b0;
    // DONE cycle; a load_start here must be ignored.
    load_start = 1'b1; load_len = 6'd0;
    #1;
    chk("l4_done", done, 1);
    chk("l4_wl", words_loaded, 4);
    chk("l4_done_busy", busy, 1);
    chk("l4_done_stall", cpu_stall, 1);
    chk("l4_done_we", mem_WE, 0);
    chk("l4_done_sready", s_ready, 0);
    tick();
    load_start = 1'b0;
    #1;
    chk("l4_run_stall", cpu_stall, 0);
    chk("l4_run_done", done, 0);
    chk("l4_ign_err", err, 0);
    chk("l4_run_busy", busy, 0);
    chk("l4_wl_hold", words_loaded, 4);
    chk("l4_run_RD", cpu_RD, 32'd4000);

    // Three-word load with gaps.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    load_start = 1'b1; load_len = 6'd3;
    tick();
    load_start = 1'b0;
    nw = 0;
    for (int k = 0; k < 6; k++) begin
      s_valid = pat[k]; s_data = 32'hB0 + k;
      #1;
      chk("gap_we", mem_WE, pat[k]);
      chk("gap_busy", busy, 1);
      if (pat[k]) begin
        chk("gap_addr", mem_A, nw);
        nw++;
      end
      tick();
    end
    s_valid = 1'b0;
    chk("gap_done", done, 1);
    chk("gap_wl", words_loaded, 3);
    chk("gap_nw", nw, 3);
    tick();
    chk("gap_run_stall", cpu_stall, 0);

    // Rejected lengths 0 and 33.
    load_start = 1'b1; load_len = 6'd0;
    tick();
    load_start = 1'b0;
    chk("len0_err", err, 1);
    chk("len0_busy", busy, 0);
    chk("len0_we", mem_WE, 0);
    chk("len0_stall", cpu_stall, 0);
    tick();
    chk("len0_err_clr", err, 0);
    load_start = 1'b1; load_len = 6'd33;
    tick();
    load_start = 1'b0;
    chk("len33_err", err, 1);
    chk("len33_busy", busy, 0);
    chk("len33_wl", words_loaded, 3);
    tick();
    chk("len33_err_clr", err, 0);

    // Reset after 2 of 5 words.
    load_start = 1'b1; load_len = 6'd5;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'hC0 + i;
      tick();
    end
    s_valid = 1'b0;
    chk("abort_wl_pre", words_loaded, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_stall", cpu_stall, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wl", words_loaded, 0);
    chk("abort_done", done, 0);
    chk("lor_sready", s_ready1, 1);
    chk("lor_busy", busy1, 1);
    chk("lor_mem_A", mem_A1, 0);
    chk("lor_wl", words_loaded1, 0);
    tick();
    chk("abort_done2", done, 0);

    // Out-of-range fetch at the boundary, then during LOAD.
    cpu_A = 32'd31;
    #1;
    chk("a31_oob", fetch_oob, 0);
    chk("a31_RD", cpu_RD, 32'd4000);
    cpu_A = 32'd32;
    #1;
    chk("a32_oob", fetch_oob, 1);
    cpu_A = 32'd40;
    #1;
    chk("a40_oob", fetch_oob, 1);
    chk("a40_RD", cpu_RD, 32'h0);
    load_start = 1'b1; load_len = 6'd1;
    tick();
    load_start = 1'b0;
    chk("a40_load_oob", fetch_oob, 0);
    chk("a40_load_stall", cpu_stall, 1);
    s_valid = 1'b1; s_data = 32'hD0;
    #1;
    chk("l1_addr", mem_A, 0);
    tick();
    s_valid = 1'b0;
    chk("l1_done", done, 1);
    chk("l1_wl", words_loaded, 1);
    tick();
    chk("l1_run_oob", fetch_oob, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
